ssp_uart_tx: RTL and testbench
==============================

Name: ssp_uart_tx

Overview:
Parametrised UART transmit engine: the next-generation TX path behind the SSP UART register interface.
- Buffers host-written characters in a FIFO and serialises them LSB-first with configurable parity and stop bits.
- Provides RS-232 output with CTS flow control, or RS-485 output with automatic driver-enable lead and trail.
- Sits between the SSP register decoder (write port) and the pad-level TxD/xDE outputs.

Parameters:
DATA_W, 8, character width in bits (5..9)
FIFO_DEPTH, 16, TX FIFO entries; power of 2, at least 2
BAUD_W, 16, width of the baud divisor

Ports:
Clk  input  1  system clock
xRst  input  1  asynchronous active-low reset
Cfg_Mode  input  1  0 = RS-232, 1 = RS-485
Cfg_Par  input  2  00 none, 01 odd, 10 even, 11 none
Cfg_Stop  input  1  0 = one stop bit, 1 = two stop bits
Cfg_HS  input  1  1 = honour xCTS (RS-232 only)
BaudDiv  input  BAUD_W  bit period = BaudDiv+1 Clk cycles
Wr  input  1  write strobe, one cycle
WrData  input  DATA_W  character to transmit
xCTS  input  1  asynchronous, active-low clear-to-send
Full  output  1  FIFO full
Empty  output  1  FIFO empty
Count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
Ovf  output  1  one-cycle pulse: write dropped because FIFO full
TxD_232  output  1  RS-232 serial data
TxD_485  output  1  RS-485 serial data
xDE  output  1  RS-485 driver enable, active low
TxIdle  output  1  FIFO empty and serialiser idle

Behaviour:
Reset values:
- TxD_232=1, TxD_485=1, xDE=1, TxIdle=1, Empty=1, Full=0, Count=0, Ovf=0.
- FSM in IDLE; baud counter=0; CTS synchroniser flops=1.
- Reset mid-frame aborts the frame immediately and discards FIFO contents.

FIFO:
- Wr with Full=0: push.
- Wr with Full=1: drop and pulse Ovf next cycle. This holds even if a pop occurs in the same cycle.
- Push and pop in the same cycle leave Count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

xCTS:
- 2-flop synchroniser. Only the synchronised value is used.

FSM states: IDLE, DE_LEAD, START, DATA, PARITY, STOP, DE_TRAIL.

Baud timing:
- Counter reloads BaudDiv on entering each bit state and decrements each cycle.
- Bit ends when counter==0, so every bit lasts BaudDiv+1 cycles.
- BaudDiv=0 gives one cycle per bit.

Start condition (IDLE):
- Requires FIFO non-empty and (Cfg_HS=0, or Cfg_Mode=1, or synchronised xCTS=0).
- On start: pop the head into the shift register and latch Cfg_Mode, Cfg_Par, Cfg_Stop, BaudDiv for the whole frame. Config changes mid-frame have no effect.
- Mode 0 goes to START. Mode 1 goes to DE_LEAD (xDE=0 for one bit period, TxD_485=1), then START.

Frame sequence:
- START drives 0.
- DATA shifts out DATA_W bits LSB-first.
- PARITY is present only if Cfg_Par is 01 or 10. Odd: total ones in data+parity is odd. Even: total is even.
- STOP drives 1 for one or two bit periods.

After the last stop bit:
- If the start condition holds, go directly to START with no idle gap; xDE stays 0 in mode 1.
- Else, mode 1 goes to DE_TRAIL (one bit period, xDE=0, line=1), then IDLE. Mode 0 goes to IDLE.

Flow control:
- CTS deassertion mid-frame never truncates the frame; it only blocks the next start.

Output routing:
- Inactive mode's TxD is held at 1.
- xDE=1 whenever mode 0 or in IDLE.

Latency:
- Wr in cycle N (FIFO empty, IDLE, mode 0, Cfg_HS=0): pop in N+1, TxD_232 goes 0 at N+2.

TxIdle:
- TxIdle = Empty && state==IDLE, registered.

Decomposition:
- Package ssp_uart_pkg holds:
  - FSM state enum;
  - parity encodings PAR_NONE/PAR_ODD/PAR_EVEN;
  - mode constants MODE_232/MODE_485.
- One sub-module, ssp_uart_fifo: synchronous FIFO parametrised by DATA_W and FIFO_DEPTH, providing Full, Empty and Count.
- FSM, baud counter, parity generator and CTS synchroniser live in ssp_uart_tx.

Test Plan:
1. Reset: assert xRst=0 mid-frame → all outputs at their reset values within the same cycle; Count=0 after release.
2. Mode 0, BaudDiv=3, no parity, 1 stop; write 0xA5 → TxD_232 = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles); TxIdle returns to 1; TxD_485=1 and xDE=1 throughout.
3. BaudDiv=1, two stop bits; write 0x07 with even parity → parity bit 1; with odd parity → parity bit 0; stop bits at 1 for 4 cycles.
4. FIFO_DEPTH=4, Cfg_HS=1, xCTS=1; write 6 bytes back-to-back → Full after the 4th, Ovf pulses twice, Count=4, TxD_232 stays 1. Drive xCTS=0 → 4 frames with no gaps, Empty=1 at the end.
5. xCTS raised mid-frame of the first of 2 queued bytes → first frame completes intact; second does not start until xCTS=0 again.
6. Mode 1, BaudDiv=2; write 2 bytes → xDE=0 for 3 cycles before the first start bit, stays 0 between frames, released 3 cycles after the final stop; TxD_232 stays 1.

Source files
------------

// File: rtl/ssp_uart_pkg.sv
// SSP UART transmit path: shared state encoding,
// parity and line-mode constants.
package ssp_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DE_LEAD,
    START,
    DATA,
    PARITY,
    STOP,
    DE_TRAIL
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam logic MODE_232 = 1'b0;
  localparam logic MODE_485 = 1'b1;

  function automatic logic par_en(input logic [1:0] p);
    return (p == PAR_ODD) || (p == PAR_EVEN);
  endfunction

endpackage

// File: rtl/ssp_uart_fifo.sv
// Synchronous character FIFO for the UART TX path.
// Caller gates Push on !Full and Pop on !Empty.
module ssp_uart_fifo #(
  parameter  int DATA_W     = 8,
  parameter  int FIFO_DEPTH = 16,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic              Clk,
  input  logic              xRst,
  input  logic              Push,
  input  logic [DATA_W-1:0] PushData,
  input  logic              Pop,
  output logic [DATA_W-1:0] PopData,
  output logic              Full,
  output logic              Empty,
  output logic [CW-1:0]     Count
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q;
  logic [AW-1:0]     rd_q;
  logic [CW-1:0]     cnt_q;

  always_ff @(posedge Clk) begin
    if (Push) mem_q[wr_q] <= PushData;
  end

  always_ff @(posedge Clk or negedge xRst) begin
    if (!xRst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (Push) wr_q <= wr_q + AW'(1);
      if (Pop)  rd_q <= rd_q + AW'(1);
      unique case ({Push, Pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign PopData = mem_q[rd_q];
  assign Full    = (cnt_q == CW'(FIFO_DEPTH));
  assign Empty   = (cnt_q == '0);
  assign Count   = cnt_q;

endmodule

// File: rtl/ssp_uart_tx.sv
// SSP UART transmit engine: FIFO, framer, baud timer,
// CTS synchroniser and RS-232 / RS-485 output routing.
module ssp_uart_tx
  import ssp_uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_W     = 16
) (
  input  logic                        Clk,
  input  logic                        xRst,
  input  logic                        Cfg_Mode,
  input  logic [1:0]                  Cfg_Par,
  input  logic                        Cfg_Stop,
  input  logic                        Cfg_HS,
  input  logic [BAUD_W-1:0]           BaudDiv,
  input  logic                        Wr,
  input  logic [DATA_W-1:0]           WrData,
  input  logic                        xCTS,
  output logic                        Full,
  output logic                        Empty,
  output logic [$clog2(FIFO_DEPTH):0] Count,
  output logic                        Ovf,
  output logic                        TxD_232,
  output logic                        TxD_485,
  output logic                        xDE,
  output logic                        TxIdle
);

  localparam logic [3:0] LAST = 4'(DATA_W - 1);

  logic              push, pop, launch, bit_end, start_ok, line;
  logic [DATA_W-1:0] head;

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] cnt_q, cnt_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic              mode_q, mode_d;
  logic [1:0]        par_q, par_d;
  logic              stop_q, stop_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              pbit_q, pbit_d;
  logic [3:0]        bit_q, bit_d;
  logic              ovf_q, idle_q;
  logic              cts1_q, cts2_q;

  assign push = Wr & ~Full;

  ssp_uart_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk      (Clk),
    .xRst     (xRst),
    .Push     (push),
    .PushData (WrData),
    .Pop      (pop),
    .PopData  (head),
    .Full     (Full),
    .Empty    (Empty),
    .Count    (Count)
  );

  // RS-485 never waits on CTS; RS-232 waits only with handshake on
  assign start_ok = ~Empty &
    (~Cfg_HS | (Cfg_Mode == MODE_485) | ~cts2_q);
  assign bit_end  = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? cnt_q : cnt_q - BAUD_W'(1);
    baud_d  = baud_q;
    mode_d  = mode_q;
    par_d   = par_q;
    stop_d  = stop_q;
    sh_d    = sh_q;
    pbit_d  = pbit_q;
    bit_d   = bit_q;
    launch  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: launch = start_ok;
      DE_LEAD: if (bit_end) begin
        state_d = START;
        cnt_d   = baud_q;
      end
      START: if (bit_end) begin
        state_d = DATA;
        cnt_d   = baud_q;
        bit_d   = '0;
      end
      DATA: if (bit_end) begin
        sh_d  = sh_q >> 1;
        cnt_d = baud_q;
        if (bit_q == LAST) begin
          bit_d   = '0;
          state_d = par_en(par_q) ? PARITY : STOP;
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end
      PARITY: if (bit_end) begin
        state_d = STOP;
        cnt_d   = baud_q;
      end
      STOP: if (bit_end) begin
        if (stop_q && bit_q == '0) begin
          bit_d = 4'd1;
          cnt_d = baud_q;
        end else if (start_ok) begin
          launch = 1'b1;
        end else if (mode_q == MODE_485) begin
          state_d = DE_TRAIL;
          cnt_d   = baud_q;
        end else begin
          state_d = IDLE;
        end
      end
      DE_TRAIL: if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // back-to-back frames skip the driver-enable lead
    if (launch) begin
      pop     = 1'b1;
      sh_d    = head;
      mode_d  = Cfg_Mode;
      par_d   = Cfg_Par;
      stop_d  = Cfg_Stop;
      baud_d  = BaudDiv;
      cnt_d   = BaudDiv;
      bit_d   = '0;
      pbit_d  = ^head ^ (Cfg_Par == PAR_ODD);
      state_d = (Cfg_Mode == MODE_485 && state_q == IDLE)
                ? DE_LEAD : START;
    end
  end

  always_ff @(posedge Clk or negedge xRst) begin
    if (!xRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      baud_q  <= '0;
      mode_q  <= MODE_232;
      par_q   <= PAR_NONE;
      stop_q  <= 1'b0;
      sh_q    <= '0;
      pbit_q  <= 1'b0;
      bit_q   <= '0;
      ovf_q   <= 1'b0;
      idle_q  <= 1'b1;
      cts1_q  <= 1'b1;
      cts2_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      baud_q  <= baud_d;
      mode_q  <= mode_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      sh_q    <= sh_d;
      pbit_q  <= pbit_d;
      bit_q   <= bit_d;
      ovf_q   <= Wr & Full;
      idle_q  <= Empty & (state_q == IDLE);
      cts1_q  <= xCTS;
      cts2_q  <= cts1_q;
    end
  end

  always_comb begin
    line = 1'b1;
    unique case (state_q)
      START:   line = 1'b0;
      DATA:    line = sh_q[0];
      PARITY:  line = pbit_q;
      default: line = 1'b1;
    endcase
  end

  assign TxD_232 = (mode_q == MODE_232) ? line : 1'b1;
  assign TxD_485 = (mode_q == MODE_485) ? line : 1'b1;
  assign xDE     = ~(mode_q == MODE_485 && state_q != IDLE);
  assign Ovf     = ovf_q;
  assign TxIdle  = idle_q;

endmodule

// File: tb/tb_ssp_uart_tx.sv
// Bench for ssp_uart_tx: directed and random frames
// checked cycle by cycle against a bit-list line model.
module tb_ssp_uart_tx;

  localparam int DW = 8;
  localparam int FD = 4;
  localparam int BW = 16;

  logic          Clk = 1'b0;
  logic          xRst;
  logic          Cfg_Mode;
  logic [1:0]    Cfg_Par;
  logic          Cfg_Stop;
  logic          Cfg_HS;
  logic [BW-1:0] BaudDiv;
  logic          Wr;
  logic [DW-1:0] WrData;
  logic          xCTS;
  logic          Full, Empty, Ovf;
  logic [2:0]    Count;
  logic          TxD_232, TxD_485, xDE, TxIdle;

  int errors = 0;
  int checks = 0;

  logic [1:0]    exp_w[$];
  logic [DW-1:0] q[$];
  logic [DW-1:0] d;
  int            m, k, p;
  logic          ov, md, st;
  logic [1:0]    pr;

  ssp_uart_tx #(
    .DATA_W     (DW),
    .FIFO_DEPTH (FD),
    .BAUD_W     (BW)
  ) dut (
    .Clk      (Clk),
    .xRst     (xRst),
    .Cfg_Mode (Cfg_Mode),
    .Cfg_Par  (Cfg_Par),
    .Cfg_Stop (Cfg_Stop),
    .Cfg_HS   (Cfg_HS),
    .BaudDiv  (BaudDiv),
    .Wr       (Wr),
    .WrData   (WrData),
    .xCTS     (xCTS),
    .Full     (Full),
    .Empty    (Empty),
    .Count    (Count),
    .Ovf      (Ovf),
    .TxD_232  (TxD_232),
    .TxD_485  (TxD_485),
    .xDE      (xDE),
    .TxIdle   (TxIdle)
  );

  always #5 Clk = ~Clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle {line, xDE} for one character frame
  task automatic add_frame(input logic [DW-1:0] v, input logic [1:0] par,
                           input logic two, input int per, input logic de);
    logic b[$];
    int   ones;
    ones = $countones(v);
    b.push_back(1'b0);
    for (int i = 0; i < DW; i++) b.push_back(v[i]);
    if (par == 2'b01) b.push_back((ones % 2) == 0);
    if (par == 2'b10) b.push_back((ones % 2) == 1);
    b.push_back(1'b1);
    if (two) b.push_back(1'b1);
    foreach (b[j]) repeat (per) exp_w.push_back({b[j], ~de});
  endtask

  task automatic add_idle(input logic x, input int n);
    repeat (n) exp_w.push_back({1'b1, x});
  endtask

  task automatic run_check(input logic m485, input string tag,
                           input int cts_at);
    int n;
    n = 0;
    while (((m485 ? xDE : TxD_232) !== 1'b0) && n < 400) begin
      @(negedge Clk);
      n++;
    end
    chk({tag, "_begin"}, 32'(n < 400), 1);
    for (int i = 0; i < exp_w.size(); i++) begin
      chk($sformatf("%s_line[%0d]", tag, i),
          m485 ? TxD_485 : TxD_232, exp_w[i][1]);
      chk($sformatf("%s_xde[%0d]", tag, i), xDE, exp_w[i][0]);
      chk($sformatf("%s_other[%0d]", tag, i),
          m485 ? TxD_232 : TxD_485, 1);
      if (i == cts_at) xCTS = 1'b1;
      @(negedge Clk);
    end
    exp_w.delete();
  endtask

  task automatic setcfg(input logic mo, input logic [1:0] pa,
                        input logic sp, input logic hs, input int bd);
    Cfg_Mode = mo;
    Cfg_Par  = pa;
    Cfg_Stop = sp;
    Cfg_HS   = hs;
    BaudDiv  = BW'(bd);
  endtask

  task automatic wr(input logic [DW-1:0] v);
    Wr     = 1'b1;
    WrData = v;
    @(negedge Clk);
    Wr     = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_txd232"}, TxD_232, 1);
    chk({tag, "_txd485"}, TxD_485, 1);
    chk({tag, "_xde"}, xDE, 1);
    chk({tag, "_txidle"}, TxIdle, 1);
    chk({tag, "_empty"}, Empty, 1);
    chk({tag, "_full"}, Full, 0);
    chk({tag, "_count"}, Count, 0);
    chk({tag, "_ovf"}, Ovf, 0);
  endtask

  initial begin
    xRst = 1'b0;
    Wr = 1'b0;
    WrData = '0;
    xCTS = 1'b0;
    setcfg(0, 2'b00, 0, 0, 0);
    repeat (3) @(negedge Clk);
    chk_reset_outs("rst");
    xRst = 1'b1;
    @(negedge Clk);

    // 0xA5, mode 0, 4 cycles per bit, with write-to-start latency
    setcfg(0, 2'b00, 0, 0, 3);
    Wr = 1'b1;
    WrData = 8'hA5;
    @(negedge Clk);
    Wr = 1'b0;
    chk("lat_pre", TxD_232, 1);
    chk("lat_notempty", Empty, 0);
    @(negedge Clk);
    chk("lat_start", TxD_232, 0);
    add_frame(8'hA5, 2'b00, 0, 4, 0);
    add_idle(1, 1);
    run_check(0, "a5", -1);
    chk("a5_txidle", TxIdle, 1);
    chk("a5_empty", Empty, 1);

    // Even then odd parity, two stop bits
    setcfg(0, 2'b10, 1, 0, 1);
    wr(8'h07);
    add_frame(8'h07, 2'b10, 1, 2, 0);
    add_idle(1, 1);
    run_check(0, "even", -1);
    setcfg(0, 2'b01, 1, 0, 1);
    wr(8'h07);
    add_frame(8'h07, 2'b01, 1, 2, 0);
    add_idle(1, 1);
    run_check(0, "odd", -1);

    // Fill past capacity while CTS holds the transmitter off
    setcfg(0, 2'b00, 0, 1, 1);
    xCTS = 1'b1;
    repeat (4) @(negedge Clk);
    m = 0;
    for (int i = 0; i < 6; i++) begin
      d = DW'($urandom);
      Wr = 1'b1;
      WrData = d;
      ov = (m == FD);
      if (!ov) begin
        q.push_back(d);
        m++;
      end
      @(negedge Clk);
      chk($sformatf("ovf[%0d]", i), Ovf, ov);
      chk($sformatf("cnt[%0d]", i), Count, m);
      chk($sformatf("full[%0d]", i), Full, 32'(m == FD));
    end
    Wr = 1'b0;
    @(negedge Clk);
    chk("ovf_end", Ovf, 0);
    for (int i = 0; i < 12; i++) chk("cts_hold", TxD_232, 1);
    repeat (12) begin
      chk("cts_hold_t", TxD_232, 1);
      @(negedge Clk);
    end
    xCTS = 1'b0;
    foreach (q[j]) add_frame(q[j], 2'b00, 0, 2, 0);
    q.delete();
    add_idle(1, 1);
    run_check(0, "burst", -1);
    chk("burst_empty", Empty, 1);

    // CTS deasserted mid-frame: current frame completes, next waits
    setcfg(0, 2'b00, 0, 1, 1);
    repeat (3) @(negedge Clk);
    q.push_back(DW'($urandom));
    q.push_back(DW'($urandom));
    wr(q[0]);
    wr(q[1]);
    add_frame(q[0], 2'b00, 0, 2, 0);
    add_idle(1, 1);
    run_check(0, "ctsmid", 4);
    chk("ctsmid_count", Count, 1);
    repeat (20) begin
      chk("ctsmid_hold", TxD_232, 1);
      @(negedge Clk);
    end
    xCTS = 1'b0;
    add_frame(q[1], 2'b00, 0, 2, 0);
    add_idle(1, 1);
    run_check(0, "ctsmid2", -1);
    q.delete();

    // RS-485: driver-enable lead, no gap between frames, trail
    setcfg(1, 2'b00, 0, 0, 2);
    q.push_back(DW'($urandom));
    q.push_back(DW'($urandom));
    wr(q[0]);
    wr(q[1]);
    add_idle(0, 3);
    add_frame(q[0], 2'b00, 0, 3, 1);
    add_frame(q[1], 2'b00, 0, 3, 1);
    add_idle(0, 3);
    add_idle(1, 1);
    run_check(1, "rs485", -1);
    chk("rs485_txidle", TxIdle, 1);
    q.delete();

    // Random configurations and one or two queued characters
    for (int it = 0; it < 10; it++) begin
      md = 1'($urandom_range(0, 1));
      pr = 2'($urandom_range(0, 3));
      st = 1'($urandom_range(0, 1));
      p  = $urandom_range(1, 4);
      k  = $urandom_range(1, 2);
      setcfg(md, pr, st, 0, p - 1);
      repeat (2) @(negedge Clk);
      for (int j = 0; j < k; j++) q.push_back(DW'($urandom));
      foreach (q[j]) wr(q[j]);
      if (md) add_idle(0, p);
      foreach (q[j]) add_frame(q[j], pr, st, p, md);
      if (md) add_idle(0, p);
      add_idle(1, 1);
      run_check(md, $sformatf("rnd%0d", it), -1);
      chk($sformatf("rnd%0d_txidle", it), TxIdle, 1);
      q.delete();
    end

    // Reset in the middle of an RS-485 frame
    setcfg(1, 2'b01, 0, 0, 3);
    wr(8'h3C);
    wr(8'hC3);
    repeat (10) @(negedge Clk);
    chk("mid_pre_xde", xDE, 0);
    xRst = 1'b0;
    #1;
    chk_reset_outs("midrst");
    @(negedge Clk);
    xRst = 1'b1;
    @(negedge Clk);
    chk("midrst_count", Count, 0);
    repeat (30) begin
      chk("midrst_quiet_xde", xDE, 1);
      chk("midrst_quiet_485", TxD_485, 1);
      @(negedge Clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
